flash_page_loader: RTL and testbench

- Consumer stage directly downstream of the QPI flash controller.
- Streams NUM contiguous flash pages into a word-wide frame/pattern memory: issues page-read commands, counts returned bytes, packs them little-endian into words and writes them to sequential memory addresses.
- Sequences the controller's cmd/page/busy handshake, absorbs its trailing extra byte, and reports done/overflow/abort status to the host logic.

---
 rtl/flash_page_loader.sv | 197 +++++++++++++++++++
 tb/tb_flash_page_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_page_loader.sv
// Streams num_pages flash pages from the QPI controller into word memory, packed little-endian; a write appears 1 cycle after a word's last byte.
// Single-entry write holding stage: a word completing while a write is still unaccepted is dropped and flagged. FLASH_PAGE_LOADER_CHECKSUM_EN enables the byte checksum.
module flash_page_loader #(
    parameter int PAGE_BYTES = 256,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    start,
    input  logic [15:0]             start_page,
    input  logic [15:0]             num_pages,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    overflow,
    output logic [15:0]             checksum,
    output logic [2:0]              fl_cmd,
    output logic [15:0]             fl_page,
    input  logic                    fl_busy,
    input  logic [7:0]              fl_rdData,
    input  logic                    fl_rdRdy,
    output logic                    mem_wr_en,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wr_data,
    input  logic                    mem_ready
);

    localparam int DW     = 8 * WORD_BYTES;
    localparam int CNT_W  = $clog2(PAGE_BYTES);
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [2:0] CMD_NOOP = 3'd0;
    localparam logic [2:0] CMD_READ = 3'd3;

    logic [2:0]        state;
    logic [15:0]       page;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] waddr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [LANE_W-1:0] lane;
    logic [DW-1:0]     pack;
    logic [DW-1:0]     word_nxt;
    logic              strobe;
    logic              word_done;
    logic              last_byte;
    logic              abort_now;
    logic              accept;

    assign abort_now = abort && (state == S_ISSUE || state == S_STREAM);
    assign strobe    = (state == S_STREAM) && fl_rdRdy && !abort;
    assign word_done = strobe && (lane == LANE_W'(WORD_BYTES - 1));
    assign last_byte = strobe && (byte_cnt == CNT_W'(PAGE_BYTES - 1));
    assign accept    = mem_wr_en && mem_ready;
    assign fl_page   = page;

    always_comb begin
        word_nxt = pack;
        word_nxt[8*lane +: 8] = fl_rdData;
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state       <= S_IDLE;
            page        <= '0;
            remaining   <= '0;
            waddr       <= '0;
            byte_cnt    <= '0;
            lane        <= '0;
            pack        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            overflow    <= 1'b0;
            fl_cmd      <= CMD_NOOP;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_pages != 16'd0) begin
                            page      <= start_page;
                            remaining <= num_pages;
                            waddr     <= base_addr;
                            aborted   <= 1'b0;
                            overflow  <= 1'b0;
                            busy      <= 1'b1;
                            fl_cmd    <= CMD_READ;
                            byte_cnt  <= '0;
                            lane      <= '0;
                            pack      <= '0;
                            state     <= S_ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort_now) begin
                        aborted <= 1'b1;
                        fl_cmd  <= CMD_NOOP;
                        state   <= S_DRAIN;
                    end else if (fl_busy) begin
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (abort_now) begin
                        aborted <= 1'b1;
                        fl_cmd  <= CMD_NOOP;
                        state   <= S_DRAIN;
                    end else if (strobe) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        lane     <= word_done ? '0 : lane + 1'b1;
                        pack     <= word_nxt;
                        if (last_byte) begin
                            fl_cmd <= CMD_NOOP;
                            state  <= S_DRAIN;
                        end
                    end
                end
                // The controller's trailing byte after NOOP lands here and is ignored.
                S_DRAIN: begin
                    if (!fl_busy) begin
                        state <= aborted ? S_FIN : S_NEXT;
                    end
                end
                S_NEXT: begin
                    page      <= page + 16'd1;
                    remaining <= remaining - 16'd1;
                    if (remaining != 16'd1) begin
                        fl_cmd   <= CMD_READ;
                        byte_cnt <= '0;
                        lane     <= '0;
                        pack     <= '0;
                        state    <= S_ISSUE;
                    end else begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (!mem_wr_en || mem_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Dropped words still consume an address so later pages stay aligned.
            if (word_done) begin
                if (mem_wr_en && !mem_ready) begin
                    overflow <= 1'b1;
                end else begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= word_nxt;
                    mem_addr    <= waddr;
                end
                waddr <= waddr + 1'b1;
            end else if (accept) begin
                mem_wr_en <= 1'b0;
            end
        end
    end

`ifdef FLASH_PAGE_LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            sum <= '0;
        end else if (state == S_IDLE && start && num_pages != 16'd0) begin
            sum <= '0;
        end else if (strobe) begin
            sum <= sum + {8'h00, fl_rdData};
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_flash_page_loader.sv
// Directed bench for flash_page_loader: a behavioural QPI controller feeds byte patterns and a negedge monitor tallies memory writes.
module tb_flash_page_loader;

    localparam int ADDR_W = 16;

`ifdef FLASH_PAGE_LOADER_CHECKSUM_EN
    localparam logic [15:0] CK_PAGE  = 16'h7F80;
    localparam logic [15:0] CK_TWO   = 16'hFF00;
    localparam logic [15:0] CK_ABORT = 16'h029A;
`else
    localparam logic [15:0] CK_PAGE  = 16'h0000;
    localparam logic [15:0] CK_TWO   = 16'h0000;
    localparam logic [15:0] CK_ABORT = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              nReset;
    logic              start;
    logic [15:0]       start_page;
    logic [15:0]       num_pages;
    logic [ADDR_W-1:0] base_addr;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              overflow;
    logic [15:0]       checksum;
    logic [2:0]        fl_cmd;
    logic [15:0]       fl_page;
    logic              fl_busy;
    logic [7:0]        fl_rdData;
    logic              fl_rdRdy;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_ready;

    int vectors = 0;
    int miscompares = 0;

    bit                clr = 1'b0;
    bit                cmd_prev = 1'b0;
    logic [ADDR_W-1:0] exp_base = '0;
    int                wr_cnt = 0;
    int                addr_err = 0;
    int                done_cnt = 0;
    int                issues = 0;
    logic [31:0]       first_data = '0;
    logic [31:0]       last_data = '0;
    logic [ADDR_W-1:0] last_addr = '0;

    flash_page_loader #(.PAGE_BYTES(256), .WORD_BYTES(4), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .start       (start),
        .start_page  (start_page),
        .num_pages   (num_pages),
        .base_addr   (base_addr),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .overflow    (overflow),
        .checksum    (checksum),
        .fl_cmd      (fl_cmd),
        .fl_page     (fl_page),
        .fl_busy     (fl_busy),
        .fl_rdData   (fl_rdData),
        .fl_rdRdy    (fl_rdRdy),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after posedge, so everything is stable at negedge.
    always @(negedge clk) begin
        if (clr) begin
            wr_cnt = 0; addr_err = 0; done_cnt = 0; issues = 0;
            first_data = '0; last_data = '0; last_addr = '0;
        end else begin
            if (nReset && mem_wr_en && mem_ready) begin
                if (wr_cnt == 0) begin
                    first_data = mem_wr_data;
                    if (mem_addr !== exp_base) addr_err++;
                end else if (mem_addr !== last_addr + 1'b1) begin
                    addr_err++;
                end
                last_addr = mem_addr;
                last_data = mem_wr_data;
                wr_cnt++;
            end
            if (done === 1'b1) done_cnt++;
            if (fl_cmd === 3'd3 && !cmd_prev) issues++;
        end
        cmd_prev = (fl_cmd === 3'd3);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input logic [ADDR_W-1:0] base);
        exp_base = base;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic go(input logic [15:0] pg, input logic [15:0] n, input logic [ADDR_W-1:0] base);
        start_page = pg;
        num_pages  = n;
        base_addr  = base;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Behavioural controller: waits for READ, streams nbytes of value = index, then one trailing 0xAA byte.
    task automatic flash_page(input int nbytes, input bit do_abort, input int rel_at,
                              input logic [ADDR_W-1:0] first_addr, output logic [15:0] seen_page);
        int k;
        k = 0;
        while (fl_cmd !== 3'd3 && k < 40) begin
            step();
            k++;
        end
        chk("issue_read", {61'd0, fl_cmd}, 64'd3);
        seen_page = fl_page;
        fl_busy = 1'b1;
        step();
        for (int i = 0; i < nbytes; i++) begin
            if (i == 4) begin
                chk("first_word", {mem_wr_en, mem_addr, mem_wr_data}, {1'b1, first_addr, 32'h03020100});
            end
            if (i == rel_at) begin
                chk("held_word", {mem_wr_en, mem_addr, mem_wr_data}, {1'b1, first_addr, 32'h03020100});
                mem_ready = 1'b1;
            end
            fl_rdRdy  = 1'b1;
            fl_rdData = 8'(i);
            step();
        end
        fl_rdRdy = 1'b0;
        if (do_abort) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_cmd_aborted", {fl_cmd, aborted}, {3'd0, 1'b1});
        end else begin
            chk("page_end_cmd", {61'd0, fl_cmd}, 64'd0);
        end
        fl_rdRdy  = 1'b1;
        fl_rdData = 8'hAA;
        step();
        fl_rdRdy = 1'b0;
        for (int h = 0; h < 2; h++) begin
            step();
            chk("drain_cmd", {61'd0, fl_cmd}, 64'd0);
        end
        fl_busy = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk(tag, {62'd0, done, busy}, 64'b10);
    endtask

    initial begin
        logic [15:0] pg0;
        logic [15:0] pg1;

        nReset = 1'b0; start = 1'b0; start_page = '0; num_pages = '0; base_addr = '0;
        abort = 1'b0; fl_busy = 1'b0; fl_rdData = '0; fl_rdRdy = 1'b0; mem_ready = 1'b1;
        step();
        step();
        chk("reset_outs", {busy, done, aborted, overflow, checksum, fl_cmd, fl_page, mem_wr_en, mem_addr},
            64'd0);
        chk("reset_data", {32'd0, mem_wr_data}, 64'd0);
        nReset = 1'b1;
        step();

        // 1: single page, ready always high
        clear_stats(16'h0100);
        go(16'h0010, 16'd1, 16'h0100);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        flash_page(256, 1'b0, -1, 16'h0100, pg0);
        chk("t1_page", {48'd0, pg0}, {48'd0, 16'h0010});
        wait_done("t1_done");
        step();
        chk("t1_writes", 64'(wr_cnt), 64'd64);
        chk("t1_first_last", {first_data, last_data}, {32'h03020100, 32'hFFFEFDFC});
        chk("t1_last_addr", {48'd0, last_addr}, {48'd0, 16'h013F});
        chk("t1_addr_err", 64'(addr_err), 64'd0);
        chk("t1_done_cnt_issues", {32'(done_cnt), 32'(issues)}, {32'd1, 32'd1});
        chk("t1_ovf_ck", {47'd0, overflow, checksum}, {47'd0, 1'b0, CK_PAGE});

        // 2: page wrap 0xFFFF -> 0x0000
        clear_stats(16'h0200);
        go(16'hFFFF, 16'd2, 16'h0200);
        flash_page(256, 1'b0, -1, 16'h0200, pg0);
        flash_page(256, 1'b0, -1, 16'h0240, pg1);
        wait_done("t2_done");
        step();
        chk("t2_pages", {32'd0, pg0, pg1}, {32'd0, 16'hFFFF, 16'h0000});
        chk("t2_writes", 64'(wr_cnt), 64'd128);
        chk("t2_last", {16'd0, last_addr, last_data}, {16'd0, 16'h027F, 32'hFFFEFDFC});
        chk("t2_addr_err_issues", {32'(addr_err), 32'(issues)}, {32'd0, 32'd2});
        chk("t2_ck", {48'd0, checksum}, {48'd0, CK_TWO});

        // 3: zero pages
        clear_stats(16'h0000);
        go(16'h0020, 16'd0, 16'h0000);
        chk("t3_done_busy", {62'd0, done, busy}, 64'b10);
        step();
        step();
        chk("t3_quiet", {59'd0, done, busy, fl_cmd}, 64'd0);
        chk("t3_no_issue", 64'(issues), 64'd0);

        // 4: backpressure during first page
        clear_stats(16'h0300);
        mem_ready = 1'b0;
        go(16'h0040, 16'd1, 16'h0300);
        flash_page(256, 1'b0, 16, 16'h0300, pg0);
        wait_done("t4_done");
        step();
        chk("t4_overflow", {63'd0, overflow}, 64'd1);
        chk("t4_writes", 64'(wr_cnt), 64'd61);
        chk("t4_first_last", {first_data, last_data}, {32'h03020100, 32'hFFFEFDFC});
        chk("t4_last_addr_gap", {16'(addr_err), 32'd0, last_addr}, {16'd1, 32'd0, 16'h033F});
        chk("t4_ck", {48'd0, checksum}, {48'd0, CK_PAGE});

        // 5: abort after 37 bytes of a 3-page request
        clear_stats(16'h0400);
        go(16'h0050, 16'd3, 16'h0400);
        flash_page(37, 1'b1, -1, 16'h0400, pg0);
        wait_done("t5_done");
        step();
        chk("t5_writes", 64'(wr_cnt), 64'd9);
        chk("t5_last", {16'd0, last_addr, last_data}, {16'd0, 16'h0408, 32'h23222120});
        chk("t5_aborted_issues", {31'd0, aborted, 32'(issues)}, {31'd0, 1'b1, 32'd1});
        chk("t5_ck", {48'd0, checksum}, {48'd0, CK_ABORT});

        // 6: new start clears aborted; start while busy ignored; reset mid-stream
        clear_stats(16'h0500);
        go(16'h0005, 16'd1, 16'h0500);
        chk("t6_clear_aborted", {62'd0, aborted, busy}, 64'b01);
        fl_busy = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            fl_rdRdy  = 1'b1;
            fl_rdData = 8'(i);
            step();
        end
        fl_rdRdy = 1'b0;
        go(16'h0077, 16'd0, 16'h0000);
        step();
        chk("t6_start_ignored", {59'd0, done, busy, fl_cmd}, {59'd0, 1'b0, 1'b1, 3'd3});
        nReset  = 1'b0;
        fl_busy = 1'b0;
        step();
        chk("t6_reset_outs", {busy, done, aborted, overflow, checksum, fl_cmd, fl_page, mem_wr_en, mem_addr},
            64'd0);
        chk("t6_reset_data", {32'd0, mem_wr_data}, 64'd0);
        nReset = 1'b1;
        step();
        chk("t6_post_reset", {60'd0, busy, fl_cmd}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
